// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, requester IDs
// and default address/data widths.
package mem_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-requester round-robin picker; req is indexed by port ID
// and a tie goes to the port that did not win last time.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       pick
);

  always_comb begin
    valid = |req;
    pick  = PORT_I;
    if (req[PORT_I] && req[PORT_D]) pick = ~last;
    else if (req[PORT_D])           pick = PORT_D;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sharing of the single-port unified memory between fetch (I) and
// load/store (D). Define MEM_ARB_WPROT_EN to reject stores at or below WPROT_TOP.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int             AW        = AW_DEF,
  parameter int             DW        = DW_DEF,
  parameter logic [AW-1:0]  WPROT_TOP = AW'('h7F)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_idata,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_odata,
  output logic          arb_busy
);

  state_t        r_state, w_next;
  logic          r_gnt, r_last;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_idata;
  logic          r_i_ack, r_d_ack, r_d_err;
  logic [DW-1:0] r_i_rdata, r_d_rdata;
  logic [1:0]    w_elig;
  logic          w_valid, w_pick, w_prot;

  // A port whose ack is showing this cycle still has its old req up; ignore it.
  assign w_elig = {d_req & ~r_d_ack, i_req & ~r_i_ack};

  rr_pick2 u_pick (
    .req   (w_elig),
    .last  (r_last),
    .valid (w_valid),
    .pick  (w_pick)
  );

`ifdef MEM_ARB_WPROT_EN
  assign w_prot = d_we & (r_mem_addr <= WPROT_TOP);
`else
  logic w_unused_top;
  assign w_unused_top = ^WPROT_TOP;
  assign w_prot       = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_next = ACCESS;
      ACCESS:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Address and write data are captured at grant so they hold after ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt       <= PORT_I;
      r_last      <= PORT_D;
      r_mem_addr  <= '0;
      r_mem_idata <= '0;
    end else if (r_state == IDLE && w_valid) begin
      r_gnt       <= w_pick;
      r_last      <= w_pick;
      r_mem_addr  <= (w_pick == PORT_D) ? d_addr : i_addr;
      r_mem_idata <= d_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_d_err   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      r_d_err <= 1'b0;
      if (r_state == ACCESS) begin
        if (r_gnt == PORT_I) begin
          r_i_rdata <= mem_odata;
          r_i_ack   <= 1'b1;
        end else begin
          r_d_ack <= 1'b1;
          r_d_err <= w_prot;
          if (!d_we) r_d_rdata <= mem_odata;
        end
      end
    end
  end

  assign mem_wr    = (r_state == ACCESS) & (r_gnt == PORT_D) & d_we & ~w_prot;
  assign mem_addr  = r_mem_addr;
  assign mem_idata = r_mem_idata;
  assign arb_busy  = (r_state == ACCESS);
  assign i_ack     = r_i_ack;
  assign i_rdata   = r_i_rdata;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 256x16 memory model on
// the mem_* pins; the protection steps adapt to MEM_ARB_WPROT_EN.
module tb_mem_arbiter;

  localparam bit WPROT =
`ifdef MEM_ARB_WPROT_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [7:0]  i_addr, d_addr;
  logic [15:0] d_wdata;
  logic        i_ack, d_ack, d_err, mem_wr, arb_busy;
  logic [15:0] i_rdata, d_rdata, mem_idata, mem_odata;
  logic [7:0]  mem_addr;

  logic [15:0] mem [256];
  int          wr_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  int          base;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_addr  (mem_addr),
    .mem_idata (mem_idata),
    .mem_wr    (mem_wr),
    .mem_odata (mem_odata),
    .arb_busy  (arb_busy)
  );

  always #5 clk = ~clk;

  assign mem_odata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr === 1'b1) begin
      mem[mem_addr] = mem_idata;
      wr_cnt        = wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    tick(); tick();
    chk("rst_i_ack",   32'(i_ack),     32'h0);
    chk("rst_d_ack",   32'(d_ack),     32'h0);
    chk("rst_d_err",   32'(d_err),     32'h0);
    chk("rst_i_rdata", 32'(i_rdata),   32'h0);
    chk("rst_d_rdata", 32'(d_rdata),   32'h0);
    chk("rst_mem_wr",  32'(mem_wr),    32'h0);
    chk("rst_addr",    32'(mem_addr),  32'h0);
    chk("rst_idata",   32'(mem_idata), 32'h0);
    chk("rst_busy",    32'(arb_busy),  32'h0);
    rst = 1'b0;
    tick();

    // single store of BEEF to 0x90
    base = wr_cnt;
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h90; d_wdata = 16'hBEEF;
    tick();
    chk("st_wr",    32'(mem_wr),   32'h1);
    chk("st_addr",  32'(mem_addr), 32'h90);
    chk("st_busy",  32'(arb_busy), 32'h1);
    chk("st_noack", 32'(d_ack),    32'h0);
    tick();
    chk("st_ack",   32'(d_ack),    32'h1);
    chk("st_err",   32'(d_err),    32'h0);
    chk("st_wr_lo", 32'(mem_wr),   32'h0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    chk("st_ack_lo", 32'(d_ack),        32'h0);
    chk("st_busy_lo", 32'(arb_busy),    32'h0);
    chk("st_wrcnt",  32'(wr_cnt - base), 32'h1);
    chk("st_mem",    32'(mem[8'h90]),   32'hBEEF);

    // fetch of 0x90
    base = wr_cnt;
    i_req = 1'b1; i_addr = 8'h90;
    tick();
    chk("f_busy",  32'(arb_busy), 32'h1);
    chk("f_wr",    32'(mem_wr),   32'h0);
    chk("f_addr",  32'(mem_addr), 32'h90);
    tick();
    chk("f_ack",   32'(i_ack),    32'h1);
    chk("f_rdata", 32'(i_rdata),  32'hBEEF);
    i_req = 1'b0;
    tick();
    chk("f_ack_lo", 32'(i_ack),        32'h0);
    chk("f_wrcnt",  32'(wr_cnt - base), 32'h0);

    // reset so the next tie is the first after reset
    rst = 1'b1; tick(); rst = 1'b0; tick();
    i_req = 1'b1; i_addr = 8'h30;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    for (int t = 1; t <= 18; t++) begin
      tick();
      chk($sformatf("rr_i_ack_t%0d", t), 32'(i_ack), 32'((t % 4) == 2));
      chk($sformatf("rr_d_ack_t%0d", t), 32'(d_ack), 32'((t % 4) == 0));
      if (t == 2)  chk("rr_i_rdata", 32'(i_rdata), 32'hA030);
      if (t == 4)  chk("rr_d_rdata", 32'(d_rdata), 32'hA020);
      if (t == 16) d_req = 1'b0;
      if (t == 18) i_req = 1'b0;
    end
    tick();
    chk("rr_quiet_i", 32'(i_ack),    32'h0);
    chk("rr_quiet_d", 32'(d_ack),    32'h0);
    chk("rr_idle",    32'(arb_busy), 32'h0);
    tick();

    // stale request held through the ack cycle
    i_req = 1'b1; i_addr = 8'h40;
    tick();
    chk("sl_busy1", 32'(arb_busy), 32'h1);
    tick();
    chk("sl_ack1",  32'(i_ack),    32'h1);
    chk("sl_rd1",   32'(i_rdata),  32'hA040);
    chk("sl_idle",  32'(arb_busy), 32'h0);
    tick();
    chk("sl_nodup", 32'(arb_busy), 32'h0);
    chk("sl_gap",   32'(i_ack),    32'h0);
    tick();
    chk("sl_busy2", 32'(arb_busy), 32'h1);
    chk("sl_gap2",  32'(i_ack),    32'h0);
    tick();
    chk("sl_ack2",  32'(i_ack),    32'h1);
    i_req = 1'b0;
    tick();
    chk("sl_end",   32'(i_ack),    32'h0);

    // async reset in the middle of a store ACCESS
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h50; d_wdata = 16'h5555;
    tick();
    chk("ar_wr_pre", 32'(mem_wr), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("ar_wr",   32'(mem_wr),   32'h0);
    chk("ar_busy", 32'(arb_busy), 32'h0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    chk("ar_noack_r", 32'(d_ack), 32'h0);
    rst = 1'b0;
    tick();
    chk("ar_idle",  32'(arb_busy), 32'h0);
    chk("ar_noack", 32'(d_ack),    32'h0);
    tick();
    chk("ar_noack2", 32'(d_ack),   32'h0);

    // store into the protectable region, then read it back
    base = wr_cnt;
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 16'h1234;
    tick();
    chk("wp_wr",   32'(mem_wr),   32'(!WPROT));
    chk("wp_busy", 32'(arb_busy), 32'h1);
    tick();
    chk("wp_ack",  32'(d_ack),    32'h1);
    chk("wp_err",  32'(d_err),    32'(WPROT));
    d_req = 1'b0; d_we = 1'b0;
    tick();
    chk("wp_err_lo", 32'(d_err),         32'h0);
    chk("wp_wrcnt",  32'(wr_cnt - base), 32'(!WPROT));
    i_req = 1'b1; i_addr = 8'h10;
    tick(); tick();
    chk("wp_f_ack", 32'(i_ack),   32'h1);
    chk("wp_f_rd",  32'(i_rdata), WPROT ? 32'hA010 : 32'h1234);
    i_req = 1'b0;
    tick();

    // store just above the protected region always writes
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h80; d_wdata = 16'h4321;
    tick();
    chk("hi_wr",  32'(mem_wr), 32'h1);
    tick();
    chk("hi_ack", 32'(d_ack),  32'h1);
    chk("hi_err", 32'(d_err),  32'h0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    i_req = 1'b1; i_addr = 8'h80;
    tick(); tick();
    chk("hi_f_ack", 32'(i_ack),   32'h1);
    chk("hi_f_rd",  32'(i_rdata), 32'h4321);
    i_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single-port 256x16 unified memory between two requesters: instruction fetch (I port, read-only) and load/store (D port, read/write).
- Sits between the core's fetch/MEM stages and the memory block; owns the memory's addr/idata/wr pins.
- Round-robin arbitration, registered read data, one-cycle ack pulse per completed access.

Parameters:
- AW, 8, memory address width (256 words)
- DW, 16, memory data width
- WPROT_TOP, 8'h7F, highest protected address (used only with the optional feature)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  AW  fetch address, stable while i_req
- i_ack  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  DW  fetched word, registered
- d_req  in  1  load/store request, held until d_ack
- d_we  in  1  1=store, 0=load; stable while d_req
- d_addr  in  AW  load/store address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle pulse, access complete
- d_rdata  out  DW  load data, registered
- d_err  out  1  store rejected by protection, valid with d_ack
- mem_addr  out  AW  to memory addr
- mem_idata  out  DW  to memory write data
- mem_wr  out  1  to memory write enable
- mem_odata  in  DW  from memory (combinational read)
- arb_busy  out  1  high while the FSM is in ACCESS

Behaviour:
- Reset (async): state=IDLE, last_gnt=D (so I wins the first tie), i_ack=d_ack=d_err=0, i_rdata=d_rdata=0, mem_wr=0, mem_addr=0, mem_idata=0, arb_busy=0.
- FSM states: IDLE, ACCESS.
- IDLE: the eligible set is the requesting ports, excluding any port whose ack is high this cycle (its req is stale).
  - None eligible -> stay in IDLE.
  - One eligible -> grant it.
  - Both eligible -> grant the port that is not last_gnt.
  - On grant: register gnt, update last_gnt, go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_addr = granted port's address.
  - mem_idata = d_wdata.
  - mem_wr = (gnt==D) & d_we, all combinational from gnt.
  - At the cycle end: the granted port's rdata <= mem_odata (loads and fetches only; on a store, d_rdata holds its previous value), its ack <= 1, state -> IDLE.
- Outside ACCESS: mem_wr=0; mem_addr holds the last value.
- Latency: request sampled in cycle N -> memory accessed in N+1 -> ack and rdata visible in N+2. Max throughput is one access per 2 cycles; back-to-back requests from alternating ports are granted in consecutive IDLE cycles.
- ack is high for exactly one cycle. A requester may drop req, or present a new request, in the ack cycle; a new request is only sampled from the following cycle.
- A requester dropping req before ack is illegal; the access still completes.
- Starvation: with both ports continuously requesting, grants alternate I, D, I, D.
- Reset asserted mid-ACCESS: returns to IDLE immediately and mem_wr drops asynchronously. A store in flight may or may not commit; no ack is issued.

Optional Feature:
- Macro: MEM_ARB_WPROT_EN.
- Defined:
  - A D-port store with d_addr <= WPROT_TOP still takes the ACCESS cycle, but mem_wr stays 0.
  - d_ack pulses with d_err=1 in the same cycle.
  - Loads and fetches are never blocked.
- Undefined: no address compare logic; d_err is tied to 0; all stores write.

Decomposition:
- Package mem_arb_pkg holds:
  - State encoding: IDLE=1'b0, ACCESS=1'b1.
  - Port IDs: PORT_I=1'b0, PORT_D=1'b1.
  - Default widths AW/DW.
- One sub-module, rr_pick2: combinational two-requester round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: valid, pick.
- The FSM, memory muxing and response registers live in mem_arbiter.

Test Plan:
- Reset then single D store: d_req=1, d_we=1, d_addr=8'h90, d_wdata=16'hBEEF.
  - Expect mem_wr=1 for exactly 1 cycle with mem_addr=8'h90.
  - Expect d_ack at N+2 with d_err=0.
- Then I fetch of 8'h90: expect i_ack at N+2 with i_rdata=16'hBEEF, and mem_wr=0 throughout.
- First tie after reset: i_req and d_req both asserted in the same cycle.
  - I is granted first.
  - D is acked 2 cycles after i_ack.
  - Sustained both-requesting gives an alternating I/D/I/D ack sequence over 8 accesses.
- Stale-req masking: I holds i_req high through its ack cycle while D is idle.
  - Expect no duplicate grant in the ack cycle.
  - Expect the next i_ack exactly 3 cycles after the first.
- Async reset pulse during ACCESS of a store:
  - Expect mem_wr=0 and arb_busy=0 immediately.
  - Expect no d_ack.
  - Expect state IDLE on the first clk after reset release.
- With MEM_ARB_WPROT_EN: a store to 8'h10 with 16'h1234 gives d_ack with d_err=1, mem_wr never high, and a later fetch of 8'h10 returns the old value. A store to 8'h80 writes normally with d_err=0.
